inst_queue: RTL and testbench

//  Circular instruction FIFO between fetch (IF) and issue_unit.
//  - Buffers fetched instructions with their PC and branch prediction.
//  - Presents the oldest entry show-ahead on the iq_* bus; issue_unit pops it with iq_re.
//  - flush empties the queue on a mispredict redirect.

---
 rtl/inst_queue_pkg.sv | 22 ++
 rtl/inst_queue_if.sv | 50 +++++
 rtl/iq_storage.sv | 28 ++
 rtl/inst_queue.sv | 112 +++++++++++
 tb/tb_inst_queue.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and sizing for the fetch-to-issue instruction queue.
// Optional same-cycle bypass is enabled by defining IQ_BYPASS_EN.
package inst_queue_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int IQ_ADDR_W = 4;
  localparam int INST_W    = 32;
  localparam int IADDR_W   = 32;

  typedef logic [INST_W-1:0]  inst_t;
  typedef logic [IADDR_W-1:0] iaddr_t;

  typedef struct packed {
    iaddr_t pred_target;
    logic   pred_taken;
    iaddr_t pc;
    inst_t  inst;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/issue bus of the instruction queue.
// slave is the queue side, master drives fetch data and iq_re.
interface inst_queue_if;
  import inst_queue_pkg::*;

  logic   if_valid;
  inst_t  if_inst;
  iaddr_t if_pc;
  logic   if_pred_taken;
  iaddr_t if_pred_target;

  logic   iq_full;
  logic   iq_empty;
  inst_t  iq_inst;
  iaddr_t iq_pc;
  logic   iq_pred_taken;
  iaddr_t iq_pred_target;
  logic   iq_re;

  modport slave (
    input  if_valid,
    input  if_inst,
    input  if_pc,
    input  if_pred_taken,
    input  if_pred_target,
    input  iq_re,
    output iq_full,
    output iq_empty,
    output iq_inst,
    output iq_pc,
    output iq_pred_taken,
    output iq_pred_target
  );

  modport master (
    output if_valid,
    output if_inst,
    output if_pc,
    output if_pred_taken,
    output if_pred_target,
    output iq_re,
    input  iq_full,
    input  iq_empty,
    input  iq_inst,
    input  iq_pc,
    input  iq_pred_taken,
    input  iq_pred_target
  );

endinterface

// File: rtl/iq_storage.sv
// Entry array of the instruction queue.
// One synchronous write port, one asynchronous read port.
module iq_storage
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  iq_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output iq_entry_t         rdata
);

  iq_entry_t mem [DEPTH];

  // Contents are qualified by count, so no clear on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and issue, show-ahead head.
// IQ_BYPASS_EN: empty queue forwards if_* straight to iq_*.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  inst_queue_if.slave  bus
);

  localparam logic [ADDR_W:0] CNT_FULL =
    DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE =
    {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic      is_empty;
  logic      is_full;
  logic      push;
  logic      pop;
  logic      bypass;
  logic      consumed;
  iq_entry_t wr_entry;
  iq_entry_t rd_entry;
  iq_entry_t out_entry;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_FULL);

  assign wr_entry = '{
    pred_target: bus.if_pred_target,
    pred_taken:  bus.if_pred_taken,
    pc:          bus.if_pc,
    inst:        bus.if_inst
  };

`ifdef IQ_BYPASS_EN
  assign bypass   = is_empty && bus.if_valid
                    && !flush;
  assign consumed = bypass && bus.iq_re;
`else
  assign bypass   = 1'b0;
  assign consumed = 1'b0;
`endif

  // A bypassed-and-consumed instruction never enters the array.
  assign push = bus.if_valid && !is_full
                && !consumed;
  assign pop  = bus.iq_re && !is_empty;

  iq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      unique case (1'b1)
        (push && !pop): count <= count + CNT_ONE;
        (pop && !push): count <= count - CNT_ONE;
        default:        count <= count;
      endcase
    end
  end

  always_comb begin
    out_entry = '0;
    unique case (1'b1)
      !is_empty: out_entry = rd_entry;
      bypass:    out_entry = wr_entry;
      default:   out_entry = '0;
    endcase
  end

  assign bus.iq_empty       = is_empty && !bypass;
  assign bus.iq_full        = is_full;
  assign bus.iq_inst        = out_entry.inst;
  assign bus.iq_pc          = out_entry.pc;
  assign bus.iq_pred_taken  = out_entry.pred_taken;
  assign bus.iq_pred_target = out_entry.pred_target;

endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue.
// Honours IQ_BYPASS_EN to match the build of the DUT.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  inst_queue_if bus ();

  inst_queue #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  iq_entry_t sb [$];

  function automatic iq_entry_t mk(logic [31:0] pc);
    iq_entry_t e;
    e.inst        = ~pc ^ 32'h1357_9BDF;
    e.pc          = pc;
    e.pred_taken  = pc[2];
    e.pred_target = pc + 32'h80;
    return e;
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(bit v, logic [31:0] pc,
                      bit re, bit fl);
    iq_entry_t e;
    iq_entry_t x;
    bit byp;
    bit psh;
    bit pp;
    e = mk(pc);
    bus.if_valid       = v;
    bus.if_inst        = e.inst;
    bus.if_pc          = e.pc;
    bus.if_pred_taken  = e.pred_taken;
    bus.if_pred_target = e.pred_target;
    bus.iq_re          = re;
    flush              = fl;
`ifdef IQ_BYPASS_EN
    byp = (sb.size() == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    @(negedge clk);
    x = '0;
    if (sb.size() != 0) x = sb[0];
    else if (byp) x = e;
    chk("empty", 32'(bus.iq_empty),
        32'(sb.size() == 0 && !byp));
    chk("full", 32'(bus.iq_full),
        32'(sb.size() == 16));
    chk("pc", bus.iq_pc, x.pc);
    chk("inst", bus.iq_inst, x.inst);
    chk("taken", 32'(bus.iq_pred_taken),
        32'(x.pred_taken));
    chk("target", bus.iq_pred_target,
        x.pred_target);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      psh = v && sb.size() < 16 && !(byp && re);
      pp  = re && sb.size() > 0;
      if (pp) void'(sb.pop_front());
      if (psh) sb.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    bus.if_valid = 1'b0;
    bus.iq_re    = 1'b0;
    flush        = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.if_inst        = '0;
    bus.if_pc          = '0;
    bus.if_pred_taken  = 1'b0;
    bus.if_pred_target = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(bus.iq_empty), 1);
    chk("rst_full", 32'(bus.iq_full), 0);
    chk("rst_inst", bus.iq_inst, 0);
    chk("rst_pc", bus.iq_pc, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++)
      step(1, 32'h100 + 32'(4 * k), 0, 0);
    idle();
    chk("cnt7", 32'(dut.count), 7);
    rst = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus.iq_empty), 1);
    chk("mid_rst_full", 32'(bus.iq_full), 0);
    chk("mid_rst_inst", bus.iq_inst, 0);
    sb.delete();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tail", 32'(dut.tail), 0);
    step(1, 32'h500, 0, 0);
    chk("tail_after", 32'(dut.tail), 1);
    step(0, 0, 1, 0);

    for (int k = 0; k < 16; k++)
      step(1, 32'(4 * k), 0, 0);
    step(1, 32'h40, 1, 0);
    chk("cnt15", 32'(dut.count), 15);
    for (int k = 0; k < 15; k++)
      step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("cnt0", 32'(dut.count), 0);

    for (int i = 0; i < 22; i++)
      step(i < 20, 32'h1000 + 32'(4 * i),
           i >= 2, 0);

    for (int k = 0; k < 5; k++)
      step(1, 32'h3000 + 32'(4 * k), 0, 0);
    chk("cnt5", 32'(dut.count), 5);
    for (int k = 0; k < 4; k++)
      step(1, 32'h3100 + 32'(4 * k), 1, 0);
    chk("cnt5_pp", 32'(dut.count), 5);

    for (int k = 0; k < 4; k++)
      step(1, 32'h3200 + 32'(4 * k), 0, 0);
    chk("cnt9", 32'(dut.count), 9);
    step(1, 32'h3280, 1, 1);
    chk("cnt_flush", 32'(dut.count), 0);
    step(0, 0, 0, 0);
    step(1, 32'h3300, 0, 0);
    step(0, 0, 1, 0);

    step(1, 32'h2000, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'h2100, 0, 1);
    step(0, 0, 0, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
